// File: rtl/pattern_scan_sched.sv
// Round-robin scheduler sharing one overlapping "11" Mealy detector among N word requesters.
// Optional SCAN_CARRY_EN keeps each channel's last shifted bit as detector history for its next word.
module pattern_scan_sched #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1,
   parameter int IW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] data_in,
   output logic [N-1:0]   gnt,
   output logic           busy,
   output logic           ser_bit,
   output logic           det,
   output logic           done,
   output logic [IW-1:0]  done_ch,
   output logic [CW-1:0]  match_cnt
);

   localparam int BW = $clog2(W);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_reg;
   logic [IW-1:0] last_reg;
   logic [W-1:0]  shift_reg;
   logic          prev_reg;
   logic [BW-1:0] bit_cnt_reg;
   logic [CW-1:0] cnt_reg;
   logic [N-1:0]  gnt_reg;
   logic          done_reg;
   logic [IW-1:0] done_ch_reg;
   logic [CW-1:0] match_cnt_reg;

   logic [W-1:0]  word [N];
   logic [IW-1:0] sel;
   logic          found;
   logic          prev_init;
   logic          in_shift;
   logic          msb;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_word
         assign word[gi] = data_in[gi*W +: W];
      end
   endgenerate

   // First requester strictly after the last grant, wrapping modulo N.
   always_comb begin
      int            k;
      logic [IW-1:0] kk;
      sel   = '0;
      found = 1'b0;
      k     = 0;
      kk    = '0;
      for (int i = 1; i <= N; i++) begin
         k  = (int'(last_reg) + i) % N;
         kk = IW'(k);
         if (!found && req[kk]) begin
            found = 1'b1;
            sel   = kk;
         end
      end
   end

`ifdef SCAN_CARRY_EN
   logic [N-1:0] carry_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_reg <= '0;
      end else if (state_reg == DONE) begin
         carry_reg[last_reg] <= prev_reg;
      end
   end

   assign prev_init = carry_reg[sel];
`else
   assign prev_init = 1'b0;
`endif

   assign in_shift  = (state_reg == SHIFT);
   assign msb       = shift_reg[W-1];
   assign ser_bit   = in_shift & msb;
   assign det       = in_shift & prev_reg & msb;
   assign busy      = (state_reg != IDLE);
   assign gnt       = gnt_reg;
   assign done      = done_reg;
   assign done_ch   = done_ch_reg;
   assign match_cnt = match_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         last_reg      <= IW'(N - 1);
         shift_reg     <= '0;
         prev_reg      <= 1'b0;
         bit_cnt_reg   <= '0;
         cnt_reg       <= '0;
         gnt_reg       <= '0;
         done_reg      <= 1'b0;
         done_ch_reg   <= '0;
         match_cnt_reg <= '0;
      end else begin
         gnt_reg  <= '0;
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (found) begin
                  shift_reg   <= word[sel];
                  gnt_reg     <= N'(1) << sel;
                  last_reg    <= sel;
                  prev_reg    <= prev_init;
                  bit_cnt_reg <= '0;
                  cnt_reg     <= '0;
                  state_reg   <= SHIFT;
               end
            end
            SHIFT: begin
               shift_reg   <= {shift_reg[W-2:0], 1'b0};
               prev_reg    <= msb;
               cnt_reg     <= cnt_reg + CW'(det);
               bit_cnt_reg <= bit_cnt_reg + BW'(1);
               // Results are captured on the way into DONE so they are valid alongside the pulse.
               if (bit_cnt_reg == BW'(W - 1)) begin
                  state_reg     <= DONE;
                  done_reg      <= 1'b1;
                  done_ch_reg   <= last_reg;
                  match_cnt_reg <= cnt_reg + CW'(det);
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Self-checking bench for pattern_scan_sched: randomized words checked against a
// behavioural model of round-robin arbitration and overlapping "11" counting.
module tb_pattern_scan_sched;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;
   localparam int IW = $clog2(N);
   localparam int PERIOD = 10;
`ifdef SCAN_CARRY_EN
   localparam bit CARRY = 1'b1;
`else
   localparam bit CARRY = 1'b0;
`endif

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           ser_bit;
   logic           det;
   logic           done;
   logic [IW-1:0]  done_ch;
   logic [CW-1:0]  match_cnt;

   int errors;
   int checks;

   // Reference model state: last granted channel and each channel's last shifted bit.
   int           mptr;
   logic [N-1:0] mcarry;

   pattern_scan_sched #(.N(N), .W(W), .CW(CW), .IW(IW)) dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt), .busy(busy),
      .ser_bit(ser_bit), .det(det), .done(done), .done_ch(done_ch), .match_cnt(match_cnt)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   function automatic int model_pick(input logic [N-1:0] r);
      for (int i = 1; i <= N; i++) begin
         if (r[(mptr + i) % N]) return (mptr + i) % N;
      end
      return -1;
   endfunction

   // Number of adjacent "11" pairs in the bit string {history, word MSB..LSB}.
   function automatic int model_count(input logic [W-1:0] w, input logic hist);
      logic [W:0] s;
      int c;
      s = {hist, w};
      c = 0;
      for (int i = 0; i < W; i++) c += (s[i] & s[i+1]) ? 1 : 0;
      return c;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mptr = N - 1;
      mcarry = '0;
   endtask

   function automatic logic [N*W-1:0] rand_data();
      logic [N*W-1:0] d;
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
      return d;
   endfunction

   // Drives one request set from a negedge, follows the granted word through SHIFT and DONE.
   task automatic do_xfer(input logic [N-1:0] r, input logic [N*W-1:0] d, input int chg_at,
                          input logic [N-1:0] chg_req, output int got_cnt, output time t_done);
      int exp_ch, exp_cnt;
      logic [W-1:0] w;
      logic prev, b_exp, seen, bad;
      req = r;
      data_in = d;
      exp_ch = model_pick(r);
      w = d[exp_ch*W +: W];
      prev = CARRY ? mcarry[exp_ch] : 1'b0;
      exp_cnt = model_count(w, prev);
      got_cnt = -1;
      t_done = 0;
      seen = 1'b0;
      for (int n = 0; n < 4 && !seen; n++) begin
         @(negedge clk);
         if (gnt !== '0) seen = 1'b1;
      end
      checks++;
      if (!seen || gnt !== (N'(1) << exp_ch)) begin
         errors++;
         $display("FAIL grant: got gnt=%b required %b", gnt, N'(1) << exp_ch);
         if (!seen) return;
      end
      bad = 1'b0;
      for (int b = 0; b < W; b++) begin
         if (b > 0) @(negedge clk);
         if (b == chg_at) begin
            req = chg_req;
            data_in = rand_data();
         end
         b_exp = w[W-1-b];
         if (ser_bit !== b_exp || det !== (prev & b_exp) || busy !== 1'b1 ||
             (b > 0 && gnt !== '0) || done !== 1'b0) begin
            bad = 1'b1;
            $display("FAIL shift bit %0d: got ser=%b det=%b busy=%b gnt=%b done=%b required ser=%b det=%b",
                     b, ser_bit, det, busy, gnt, done, b_exp, prev & b_exp);
         end
         prev = b_exp;
      end
      checks++;
      if (bad) errors++;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || match_cnt !== CW'(exp_cnt) || done_ch !== IW'(exp_ch) ||
          ser_bit !== 1'b0 || det !== 1'b0 || gnt !== '0) begin
         errors++;
         $display("FAIL done: got done=%b cnt=%0d ch=%0d ser=%b det=%b required done=1 cnt=%0d ch=%0d",
                  done, match_cnt, done_ch, ser_bit, det, exp_cnt, exp_ch);
      end
      got_cnt = int'(match_cnt);
      t_done = $time;
      mptr = exp_ch;
      mcarry[exp_ch] = w[0];
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (gnt !== '0 || busy !== 1'b0 || done !== 1'b0 || done_ch !== '0 ||
          match_cnt !== '0 || ser_bit !== 1'b0 || det !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got gnt=%b busy=%b done=%b ch=%0d cnt=%0d ser=%b det=%b required all 0",
                  gnt, busy, done, done_ch, match_cnt, ser_bit, det);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b gnt=%b required 0", busy, gnt);
         end
      end
   endtask

   task automatic test_basic();
      logic [N*W-1:0] d;
      int c;
      time t;
      do_reset();
      d = rand_data();
      d[0 +: W] = 8'b1110_0111;
      do_xfer(4'b0001, d, -1, '0, c, t);
      req = '0;
      checks++;
      if (c !== 4) begin
         errors++;
         $display("FAIL basic_cnt: got %0d required 4", c);
      end
   endtask

   task automatic test_patterns();
      logic [W-1:0] pats [3];
      int exp [3];
      logic [N*W-1:0] d;
      int c;
      time t;
      pats[0] = 8'hFF; exp[0] = 7;
      pats[1] = 8'hAA; exp[1] = 0;
      pats[2] = 8'h00; exp[2] = 0;
      for (int i = 0; i < 3; i++) begin
         d = rand_data();
         d[2*W +: W] = pats[i];
         do_xfer(4'b0100, d, -1, '0, c, t);
         checks++;
         if (c !== exp[i]) begin
            errors++;
            $display("FAIL pattern_%02h: got %0d required %0d", pats[i], c, exp[i]);
         end
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      int order [5];
      int c;
      time t, tprev;
      order = '{0, 1, 2, 3, 0};
      do_reset();
      tprev = 0;
      for (int i = 0; i < 5; i++) begin
         do_xfer(4'b1111, rand_data(), -1, '0, c, t);
         checks++;
         if (done_ch !== IW'(order[i])) begin
            errors++;
            $display("FAIL rr_order %0d: got ch=%0d required %0d", i, done_ch, order[i]);
         end
         if (i > 0) begin
            checks++;
            if (t - tprev !== time'((W + 2) * PERIOD)) begin
               errors++;
               $display("FAIL rr_spacing %0d: got %0t required %0d", i, t - tprev, (W + 2) * PERIOD);
            end
         end
         tprev = t;
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      logic [N*W-1:0] d;
      logic seen;
      int c;
      time t;
      d = rand_data();
      d[1*W +: W] = 8'hFF;
      do_xfer(4'b0010, d, -1, '0, c, t);
      req = '0;
      @(negedge clk);
      req = 4'b0001;
      data_in = rand_data();
      seen = 1'b0;
      for (int n = 0; n < 4 && !seen; n++) begin
         @(negedge clk);
         if (gnt !== '0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midrst_grant: got gnt=%b required 0001", gnt);
      end
      for (int n = 0; n < 4; n++) @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      mptr = N - 1;
      mcarry = '0;
      checks++;
      if (busy !== 1'b0 || gnt !== '0 || done !== 1'b0 || match_cnt !== '0 || done_ch !== '0) begin
         errors++;
         $display("FAIL midrst_state: got busy=%b gnt=%b done=%b cnt=%0d ch=%0d required all 0",
                  busy, gnt, done, match_cnt, done_ch);
      end
      seen = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL midrst_no_done: got done=1 required 0");
      end
      do_xfer(4'($urandom_range(1, 15)), rand_data(), -1, '0, c, t);
      req = '0;
   endtask

   task automatic test_carry();
      logic [N*W-1:0] d;
      int c1, c2;
      time t;
      d = rand_data();
      d[1*W +: W] = 8'h01;
      do_xfer(4'b0010, d, -1, '0, c1, t);
      do_xfer(4'b0100, rand_data(), -1, '0, c2, t);
      d = rand_data();
      d[1*W +: W] = 8'h80;
      do_xfer(4'b0010, d, -1, '0, c2, t);
      req = '0;
      checks++;
      if (c1 !== 0 || c2 !== (CARRY ? 1 : 0)) begin
         errors++;
         $display("FAIL carry: got %0d then %0d required 0 then %0d", c1, c2, CARRY ? 1 : 0);
      end
   endtask

   task automatic test_req_change();
      int c;
      time t;
      do_xfer(4'b0001, rand_data(), 3, 4'b1001, c, t);
      do_xfer(4'b1001, rand_data(), -1, '0, c, t);
      req = '0;
      checks++;
      if (done_ch !== IW'(3)) begin
         errors++;
         $display("FAIL req_change_next: got ch=%0d required 3", done_ch);
      end
   endtask

   task automatic test_random();
      int c;
      time t;
      for (int i = 0; i < 40; i++) begin
         do_xfer(4'($urandom_range(1, 15)), rand_data(), -1, '0, c, t);
      end
      req = '0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      req = '0;
      data_in = '0;
      mptr = N - 1;
      mcarry = '0;
      test_reset();
      test_basic();
      test_patterns();
      test_back_to_back();
      test_reset_mid();
      test_carry();
      test_req_change();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
